// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, micro-step encoding
// and bit positions inside the internal control word.
package control_sequencer_pkg;

  // Micro-step encoding; every instruction starts at T0.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  // Instruction opcodes; 0x9..0xD are undefined and behave as NOP.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit indices. CW_LAST marks the final step of an
  // instruction; CW_HALT marks the step that sets the halt latch.
  localparam int CW_PC_OUT     = 0;
  localparam int CW_PC_INC     = 1;
  localparam int CW_PC_LOAD    = 2;
  localparam int CW_MAR_LOAD   = 3;
  localparam int CW_RAM_OUT    = 4;
  localparam int CW_RAM_IN     = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_IR_OUT     = 7;
  localparam int CW_A_LOAD     = 8;
  localparam int CW_A_OUT      = 9;
  localparam int CW_B_LOAD     = 10;
  localparam int CW_ALU_OUT    = 11;
  localparam int CW_ALU_SUB    = 12;
  localparam int CW_FLAGS_LOAD = 13;
  localparam int CW_OUT_LOAD   = 14;
  localparam int CW_LAST       = 15;
  localparam int CW_HALT       = 16;
  localparam int CW_WIDTH      = 17;

  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode table: maps (step, opcode, flags) to a control word.
// Fetch (T0/T1) is common to all opcodes; execution starts at T2.
module microcode_rom
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4
) (
  input  step_e                   step,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    carry,
  input  logic                    zero,
  output ctrl_word_t              word
);

  // Decode one control word per step; anything not set stays 0.
  always_comb begin
    word = '0;
    case (step)
      T0: begin
        word[CW_PC_OUT]   = 1'b1;
        word[CW_MAR_LOAD] = 1'b1;
      end
      T1: begin
        word[CW_RAM_OUT] = 1'b1;
        word[CW_IR_LOAD] = 1'b1;
        word[CW_PC_INC]  = 1'b1;
      end
      T2: begin
        case (opcode)
          OPCODE_WIDTH'(OP_LDA), OPCODE_WIDTH'(OP_ADD),
          OPCODE_WIDTH'(OP_SUB), OPCODE_WIDTH'(OP_STA): begin
            word[CW_IR_OUT]   = 1'b1;
            word[CW_MAR_LOAD] = 1'b1;
          end
          OPCODE_WIDTH'(OP_LDI): begin
            word[CW_IR_OUT] = 1'b1;
            word[CW_A_LOAD] = 1'b1;
            word[CW_LAST]   = 1'b1;
          end
          OPCODE_WIDTH'(OP_JMP): begin
            word[CW_IR_OUT]  = 1'b1;
            word[CW_PC_LOAD] = 1'b1;
            word[CW_LAST]    = 1'b1;
          end
          OPCODE_WIDTH'(OP_JC): begin
            word[CW_IR_OUT]  = 1'b1;
            word[CW_PC_LOAD] = carry;
            word[CW_LAST]    = 1'b1;
          end
          OPCODE_WIDTH'(OP_JZ): begin
            word[CW_IR_OUT]  = 1'b1;
            word[CW_PC_LOAD] = zero;
            word[CW_LAST]    = 1'b1;
          end
          OPCODE_WIDTH'(OP_OUT): begin
            word[CW_A_OUT]    = 1'b1;
            word[CW_OUT_LOAD] = 1'b1;
            word[CW_LAST]     = 1'b1;
          end
          OPCODE_WIDTH'(OP_HLT): begin
            word[CW_HALT] = 1'b1;
            word[CW_LAST] = 1'b1;
          end
          OPCODE_WIDTH'(OP_NOP): begin
            word[CW_LAST] = 1'b1;
          end
          default: begin
            // Undefined opcodes behave exactly like NOP.
            word[CW_LAST] = 1'b1;
          end
        endcase
      end
      T3: begin
        case (opcode)
          OPCODE_WIDTH'(OP_LDA): begin
            word[CW_RAM_OUT] = 1'b1;
            word[CW_A_LOAD]  = 1'b1;
            word[CW_LAST]    = 1'b1;
          end
          OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
            word[CW_RAM_OUT] = 1'b1;
            word[CW_B_LOAD]  = 1'b1;
          end
          OPCODE_WIDTH'(OP_STA): begin
            word[CW_A_OUT]  = 1'b1;
            word[CW_RAM_IN] = 1'b1;
            word[CW_LAST]   = 1'b1;
          end
          default: begin
            // Only reachable if the opcode changes mid-instruction: end it.
            word[CW_LAST] = 1'b1;
          end
        endcase
      end
      T4: begin
        case (opcode)
          OPCODE_WIDTH'(OP_ADD): begin
            word[CW_ALU_OUT]    = 1'b1;
            word[CW_A_LOAD]     = 1'b1;
            word[CW_FLAGS_LOAD] = 1'b1;
            word[CW_LAST]       = 1'b1;
          end
          OPCODE_WIDTH'(OP_SUB): begin
            word[CW_ALU_OUT]    = 1'b1;
            word[CW_ALU_SUB]    = 1'b1;
            word[CW_A_LOAD]     = 1'b1;
            word[CW_FLAGS_LOAD] = 1'b1;
            word[CW_LAST]       = 1'b1;
          end
          default: begin
            word[CW_LAST] = 1'b1;
          end
        endcase
      end
      default: begin
        // Unused step codes recover to T0 on the next enabled edge.
        word[CW_LAST] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step sequencer for a simple 8-bit style CPU. Holds the step counter
// and halt latch; control lines come from the microcode table and are
// suppressed during reset and while halted.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    mclk,
  input  logic                    i_rst_n,
  input  logic                    mclk_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_carry,
  input  logic                    i_zero,
  output logic                    o_pc_out,
  output logic                    o_pc_inc,
  output logic                    o_pc_load,
  output logic                    o_mar_load,
  output logic                    o_ram_out,
  output logic                    o_ram_in,
  output logic                    o_ir_load,
  output logic                    o_ir_out,
  output logic                    o_a_load,
  output logic                    o_a_out,
  output logic                    o_b_load,
  output logic                    o_alu_out,
  output logic                    o_alu_sub,
  output logic                    o_flags_load,
  output logic                    o_out_load,
  output logic                    o_halt,
  output logic [STEP_WIDTH-1:0]   o_step
);

  step_e      step_r;
  logic       halt_r;
  ctrl_word_t word_s;
  logic       run_s;

  microcode_rom #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_rom (
    .step   (step_r),
    .opcode (i_opcode),
    .carry  (i_carry),
    .zero   (i_zero),
    .word   (word_s)
  );

  // Step counter and halt latch: advance on enabled edges, wrap to T0 after
  // the final step, freeze once halted until reset.
  always_ff @(posedge mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_r <= T0;
      halt_r <= 1'b0;
    end else if (mclk_en && !halt_r) begin
      if (word_s[CW_LAST]) begin
        step_r <= T0;
        halt_r <= word_s[CW_HALT];
      end else begin
        step_r <= step_e'(step_r + 3'd1);
      end
    end
  end

  // Control lines are live only out of reset and while not halted; the
  // reset term makes them drop immediately when i_rst_n falls.
  assign run_s = i_rst_n & ~halt_r;

  assign o_pc_out     = word_s[CW_PC_OUT]     & run_s;
  assign o_pc_inc     = word_s[CW_PC_INC]     & run_s;
  assign o_pc_load    = word_s[CW_PC_LOAD]    & run_s;
  assign o_mar_load   = word_s[CW_MAR_LOAD]   & run_s;
  assign o_ram_out    = word_s[CW_RAM_OUT]    & run_s;
  assign o_ram_in     = word_s[CW_RAM_IN]     & run_s;
  assign o_ir_load    = word_s[CW_IR_LOAD]    & run_s;
  assign o_ir_out     = word_s[CW_IR_OUT]     & run_s;
  assign o_a_load     = word_s[CW_A_LOAD]     & run_s;
  assign o_a_out      = word_s[CW_A_OUT]      & run_s;
  assign o_b_load     = word_s[CW_B_LOAD]     & run_s;
  assign o_alu_out    = word_s[CW_ALU_OUT]    & run_s;
  assign o_alu_sub    = word_s[CW_ALU_SUB]    & run_s;
  assign o_flags_load = word_s[CW_FLAGS_LOAD] & run_s;
  assign o_out_load   = word_s[CW_OUT_LOAD]   & run_s;
  assign o_halt       = halt_r;
  assign o_step       = STEP_WIDTH'(step_r);

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: Control_Sequencer

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 4, the width of the instruction opcode field.
REQ-002 SHALL have parameter STEP_WIDTH, default 3, the width of the micro-step counter.
REQ-003 SHALL have ports, clock and reset first:
- mclk  input  1  system clock; one clock for the whole block.
- i_rst_n  input  1  reset; asynchronous, active-low.
- mclk_en  input  1  clock enable; state advances only on mclk edges where mclk_en=1.
- i_opcode  input  OPCODE_WIDTH  opcode field of the instruction register.
- i_carry  input  1  registered carry flag.
- i_zero  input  1  registered zero flag.
- o_pc_out, o_pc_inc, o_pc_load  output  1 each  program-counter bus drive / increment / load.
- o_mar_load  output  1  memory address register load.
- o_ram_out, o_ram_in  output  1 each  RAM bus drive / RAM write.
- o_ir_load, o_ir_out  output  1 each  instruction register load / operand bus drive.
- o_a_load, o_a_out, o_b_load  output  1 each  A register load / A bus drive / B register load.
- o_alu_out, o_alu_sub, o_flags_load  output  1 each  ALU bus drive / subtract select / flags register load.
- o_out_load  output  1  output register load.
- o_halt  output  1  halt; drives the program counter halt input.
- o_step  output  STEP_WIDTH  current micro-step T0..T4.

Function
REQ-004 SHALL hold a step register T0..T4; on an enabled edge it advances by one, or returns to T0 after the current instruction's final step.
REQ-005 SHALL decode control outputs combinationally from step, i_opcode, i_carry and i_zero; each output not listed as asserted for a step SHALL be 0.
REQ-006 SHALL assert in T0: o_pc_out and o_mar_load, for every opcode.
REQ-007 SHALL assert in T1: o_ram_out, o_ir_load and o_pc_inc, for every opcode.
REQ-008 SHALL decode opcodes from T2 onward; an asterisk (*) marks the final step:
- NOP 0x0: T2* empty.
- LDA 0x1: T2 ir_out+mar_load; T3* ram_out+a_load.
- ADD 0x2: T2 ir_out+mar_load; T3 ram_out+b_load; T4* alu_out+a_load+flags_load.
- SUB 0x3: as ADD, with o_alu_sub also asserted in T4.
- STA 0x4: T2 ir_out+mar_load; T3* a_out+ram_in.
- LDI 0x5: T2* ir_out+a_load.
- JMP 0x6: T2* ir_out+pc_load.
- JC 0x7: T2* ir_out, plus pc_load only if i_carry=1.
- JZ 0x8: T2* ir_out, plus pc_load only if i_zero=1.
- OUT 0xE: T2* a_out+out_load.
- HLT 0xF: T2* empty, and sets halt.
REQ-009 SHALL treat undefined opcodes 0x9..0xD exactly as NOP.
REQ-010 SHALL never assert o_pc_inc and o_pc_load in the same step.
REQ-011 SHALL set a registered halt latch on the enabled edge that ends HLT T2; o_halt equals the latch.
REQ-012 SHALL, while halted: hold step at T0, force all other control outputs to 0, and clear the halt latch only by reset.
REQ-013 SHALL, on edges where mclk_en=0, hold step and halt state unchanged; outputs stay stable.

Reset
REQ-014 SHALL, while i_rst_n=0 (asynchronously), set step=T0 and halt=0, and force every control output including o_halt to 0.
REQ-015 SHALL, if reset asserts mid-instruction, discard that instruction; after release the first output word SHALL be T0's.

Structure
REQ-016 SHALL take the following from a shared package: opcode constants, step encoding T0..T4, and control-word bit indices.
REQ-017 SHALL place the decode table in one combinational sub-module, Microcode_Rom (inputs step, opcode, carry, zero; output control word).

Verification
REQ-018 LDA (i_opcode=0x1), mclk_en=1 -> T0 pc_out+mar_load, T1 ram_out+ir_load+pc_inc, T2 ir_out+mar_load, T3 ram_out+a_load, then step=T0 after 4 enabled edges.
REQ-019 ADD then SUB -> each takes 5 steps; o_alu_sub=1 only in SUB T4; o_flags_load=1 in T4 of both.
REQ-020 JC with i_carry=0 -> T2 ir_out only, o_pc_load=0; repeat with i_carry=1 -> T2 o_pc_load=1.
REQ-021 HLT -> o_halt=1 after T2 edge; o_step=0 and other outputs 0 for 20 cycles; pulse i_rst_n low -> o_halt=0.
REQ-022 mclk_en high 1 cycle in 3 during ADD -> step advances only on enabled edges; instruction completes after 5 enabled edges.
REQ-023 i_rst_n low asynchronously during ADD T3 -> o_step=0 and all outputs 0 immediately; after release T0 word appears.
